bus_arbiter_4: RTL and testbench
================================

# bus_arbiter_4

Round-robin arbiter that shares the single internal CPU bus among four bus masters: the register-file read port, the ALU result path, the memory data register and the I/O input port. It grants ownership to one requester at a time, inserts one idle turnaround cycle between owners, and produces the one-hot drive enable consumed by the bus multiplexer. It sits between the control unit's per-master bus requests and the bus encoder/multiplexer.

## Interface
- MAX_HOLD, 16: maximum consecutive GRANT cycles for one owner when the timeout is compiled in; legal range 2..255.
- clock  in  1  system clock; all state updates on its rising edge.
- clear  in  1  synchronous, active-high reset.
- req  in  4  request per master; bit i held high while master i wants or owns the bus.
- grant  out  4  registered one-hot bus-drive enable; all zero when no owner.
- grant_idx  out  2  index of current owner; 0 when no owner.
- grant_valid  out  1  high while any grant bit is high.
- timeout  out  1  one-cycle pulse when an owner is forcibly released.

## Operation
- State machine, states IDLE, GRANT, TURN.
  - IDLE: if req is nonzero, select winner, go to GRANT; otherwise stay.
  - GRANT: while req[owner]=1 (and no forced release), stay. When req[owner]=0, go to TURN.
  - TURN: grant is all zero for this cycle. If req is nonzero, select a winner and go to GRANT; otherwise go to IDLE.
- Winner selection: scan req starting at index ptr, ascending mod 4; the first set bit wins.
- ptr: 2-bit. On every exit from GRANT, ptr <= owner+1 (mod 4; 3 wraps to 0). A releasing master re-requesting therefore has lowest priority.
- Output encoding: grant = decoder_2_4(grant_idx) gated by grant_valid.
- Requests from non-owners during GRANT are ignored until the next TURN or IDLE arbitration. A request that drops before it is sampled is never granted.
- Reset values: state IDLE, grant 4'b0000, grant_idx 0, grant_valid 0, timeout 0, ptr 0, hold counter 0.
- Reset mid-operation: clear overrides everything. Grant drops at the same edge, and state returns to IDLE.

## Timing
- Grant latency: req sampled high at edge k from IDLE produces grant high after edge k (visible in cycle k+1).
- Release: req[owner] sampled low at edge k drops grant at edge k, giving the TURN cycle. The next winner is granted at edge k+1.
- Back-to-back owners are therefore separated by exactly one all-zero cycle.
- grant, grant_idx and grant_valid change only on clock edges; no combinational path from req to outputs.

## Configuration
- BUS_ARB_TIMEOUT_EN defined:
  - Hold counter is ceil(log2(MAX_HOLD)) bits wide. It is zeroed on entry to GRANT and increments each GRANT cycle.
  - If the counter equals MAX_HOLD-1 and any other req bit is high, the owner is forced to TURN at the next edge, with timeout high for that one cycle.
  - If the owner drops req at the same edge the limit is reached, the release is normal and timeout stays 0.
  - With no competing requests, the counter saturates at MAX_HOLD-1 and the owner keeps the bus.
- Not defined: no counter, timeout tied to 0, and an owner holds the bus indefinitely.

## Structure
- Shared package bus_arb_pkg:
  - state enum (IDLE, GRANT, TURN);
  - NUM_MASTERS=4;
  - master index constants (MST_REGF=0, MST_ALU=1, MST_MDR=2, MST_INPORT=3).
- Sub-module: instantiate the existing decoder_2_4 for the index-to-one-hot conversion. The round-robin scan stays inline.

## Test plan
- Reset: assert clear with req=4'b1111 → all outputs 0. After release, grant=4'b0001 one cycle later (ptr=0).
- Single requester: req=4'b0100 from IDLE → grant=4'b0100, grant_idx=2 next cycle. Drop req → one zero cycle, then IDLE.
- Round robin: req=4'b1111 held, each owner drops and re-raises req after 3 GRANT cycles → grant order 0001, 0010, 0100, 1000, 0001, with one zero cycle between each.
- Wrap-around: owner 3 releases while req=4'b1001 → next grant 4'b0001, not 4'b1000.
- Timeout (BUS_ARB_TIMEOUT_EN, MAX_HOLD=4): owner 0 holds req, req[1] raised → grant 0001 for exactly 4 cycles, timeout pulse on the TURN cycle, then grant 0010. Without the macro, 0001 persists beyond 100 cycles.
- Reset mid-grant: clear pulsed during GRANT of master 2 → grant zero next edge. After clear deasserts with req=4'b0100, grant=4'b0100 from ptr 0 scan.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared definitions for the four-master internal bus arbiter:
// FSM state encoding, master count and the fixed master slot assignments.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_t;

  localparam int NUM_MASTERS = 4;

  localparam logic [1:0] MST_REGF   = 2'd0;
  localparam logic [1:0] MST_ALU    = 2'd1;
  localparam logic [1:0] MST_MDR    = 2'd2;
  localparam logic [1:0] MST_INPORT = 2'd3;

endpackage

// File: rtl/decoder_2_4.sv
// 2-to-4 one-hot decoder with enable; drives the bus multiplexer select lines.
module decoder_2_4
  import bus_arb_pkg::*;
(
  input  logic [1:0]             idx,
  input  logic                   en,
  output logic [NUM_MASTERS-1:0] onehot
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_dec
      assign onehot[gi] = en && (idx == 2'(gi));
    end
  endgenerate

endmodule

// File: rtl/bus_arbiter_4.sv
// Round-robin owner arbiter for the shared CPU bus, with one idle turnaround cycle
// between owners. Optional forced-release hold limit: BUS_ARB_TIMEOUT_EN.
module bus_arbiter_4
  import bus_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
)
(
  input  logic                   clock,
  input  logic                   clear,
  input  logic [NUM_MASTERS-1:0] req,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [1:0]             grant_idx,
  output logic                   grant_valid,
  output logic                   timeout
);

  generate
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
      $error("bus_arbiter_4: MAX_HOLD out of range 2..255");
    end
  endgenerate

  arb_state_t             state_reg, state_next;
  logic [1:0]             idx_reg, idx_next;
  logic                   valid_reg, valid_next;
  logic [1:0]             ptr_reg, ptr_next;
  logic                   timeout_reg, timeout_next;
  logic [NUM_MASTERS-1:0] grant_reg, grant_next;
  logic                   win_found;
  logic [1:0]             win_idx;
  logic                   force_release;

  // Scan upward from ptr (mod 4); the first requester found wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_reg;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!win_found && req[ptr_reg + 2'(i)]) begin
        win_found = 1'b1;
        win_idx   = ptr_reg + 2'(i);
      end
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD);

  logic [HW-1:0] hold_reg, hold_next;
  logic          hold_limit;
  logic          others_req;

  assign hold_limit = (hold_reg == HW'(MAX_HOLD - 1));
  // grant_reg is the owner's one-hot while in GRANT, so this masks out the owner.
  assign others_req = |(req & ~grant_reg);
  // An owner dropping req on the limit edge is a normal release, not a timeout.
  assign force_release = (state_reg == GRANT) && hold_limit && others_req
                         && req[idx_reg];

  always_comb begin
    hold_next = hold_reg;
    if (state_reg == GRANT && !hold_limit)
      hold_next = hold_reg + HW'(1);
    if (state_next == GRANT && state_reg != GRANT)
      hold_next = '0;
  end

  always_ff @(posedge clock) begin
    if (clear)
      hold_reg <= '0;
    else
      hold_reg <= hold_next;
  end
`else
  assign force_release = 1'b0;
`endif

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    valid_next   = valid_reg;
    ptr_next     = ptr_reg;
    timeout_next = 1'b0;
    unique case (state_reg)
      IDLE, TURN: begin
        if (win_found) begin
          state_next = GRANT;
          idx_next   = win_idx;
          valid_next = 1'b1;
        end else begin
          state_next = IDLE;
          idx_next   = 2'd0;
          valid_next = 1'b0;
        end
      end
      GRANT: begin
        if (!req[idx_reg] || force_release) begin
          state_next   = TURN;
          idx_next     = 2'd0;
          valid_next   = 1'b0;
          ptr_next     = idx_reg + 2'd1;
          timeout_next = force_release;
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = 2'd0;
        valid_next = 1'b0;
      end
    endcase
  end

  // Decode the next owner so the drive enables come straight from flops.
  decoder_2_4 u_dec (
    .idx    (idx_next),
    .en     (valid_next),
    .onehot (grant_next)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      state_reg   <= IDLE;
      idx_reg     <= 2'd0;
      valid_reg   <= 1'b0;
      ptr_reg     <= 2'd0;
      timeout_reg <= 1'b0;
      grant_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      valid_reg   <= valid_next;
      ptr_reg     <= ptr_next;
      timeout_reg <= timeout_next;
      grant_reg   <= grant_next;
    end
  end

  assign grant       = grant_reg;
  assign grant_idx   = idx_reg;
  assign grant_valid = valid_reg;
  assign timeout     = timeout_reg;

endmodule

// File: tb/tb_bus_arbiter_4.sv
// Directed scoreboard bench for bus_arbiter_4 (MAX_HOLD=4); expectations follow
// BUS_ARB_TIMEOUT_EN when the bench is built with it.
module tb_bus_arbiter_4;

  logic       clock = 1'b0;
  logic       clear;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  typedef struct {
    int         due;
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  bus_arbiter_4 #(.MAX_HOLD(4)) dut (
    .clock       (clock),
    .clear       (clear),
    .req         (req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Apply one cycle of inputs; eg/et are the outputs expected after the next edge.
  task automatic step(input logic [3:0] r, input logic c, input logic [3:0] eg,
                      input logic et, input string nm);
    exp_t e;
    req    = r;
    clear  = c;
    e.due  = cyc + 1;
    e.exp  = {eg, idx_of(eg), |eg, et};
    e.name = nm;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      exp_t e;
      logic [7:0] act;
      e   = sb_q.pop_front();
      act = {grant, grant_idx, grant_valid, timeout};
      n_cmp++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s @cyc %0d: got grant=%b idx=%0d valid=%b timeout=%b, expected grant=%b idx=%0d valid=%b timeout=%b",
                 e.name, cyc, act[7:4], act[3:2], act[1], act[0],
                 e.exp[7:4], e.exp[3:2], e.exp[1], e.exp[0]);
      end
    end
  end

  initial begin
    req   = 4'b0000;
    clear = 1'b1;
    @(posedge clock);
    #1;

    // reset with all requests pending
    step(4'b1111, 1'b1, 4'b0000, 1'b0, "reset_hold");
    step(4'b1111, 1'b1, 4'b0000, 1'b0, "reset_hold");
    step(4'b1111, 1'b0, 4'b0001, 1'b0, "after_reset_ptr0");
    step(4'b0000, 1'b0, 4'b0000, 1'b0, "release_turn");
    step(4'b0000, 1'b0, 4'b0000, 1'b0, "idle");

    // single requester (ptr=1)
    step(4'b0100, 1'b0, 4'b0100, 1'b0, "single_grant");
    step(4'b0100, 1'b0, 4'b0100, 1'b0, "single_hold");
    step(4'b0000, 1'b0, 4'b0000, 1'b0, "single_turn");
    step(4'b0000, 1'b0, 4'b0000, 1'b0, "single_idle");

    // round robin from ptr 0, each owner holds 3 cycles
    step(4'b0000, 1'b1, 4'b0000, 1'b0, "rr_clear");
    step(4'b1111, 1'b0, 4'b0001, 1'b0, "rr_own0");
    step(4'b1111, 1'b0, 4'b0001, 1'b0, "rr_own0");
    step(4'b1111, 1'b0, 4'b0001, 1'b0, "rr_own0");
    step(4'b1110, 1'b0, 4'b0000, 1'b0, "rr_turn0");
    step(4'b1111, 1'b0, 4'b0010, 1'b0, "rr_own1");
    step(4'b1111, 1'b0, 4'b0010, 1'b0, "rr_own1");
    step(4'b1111, 1'b0, 4'b0010, 1'b0, "rr_own1");
    step(4'b1101, 1'b0, 4'b0000, 1'b0, "rr_turn1");
    step(4'b1111, 1'b0, 4'b0100, 1'b0, "rr_own2");
    step(4'b1111, 1'b0, 4'b0100, 1'b0, "rr_own2");
    step(4'b1111, 1'b0, 4'b0100, 1'b0, "rr_own2");
    step(4'b1011, 1'b0, 4'b0000, 1'b0, "rr_turn2");
    step(4'b1111, 1'b0, 4'b1000, 1'b0, "rr_own3");
    step(4'b1111, 1'b0, 4'b1000, 1'b0, "rr_own3");
    step(4'b1111, 1'b0, 4'b1000, 1'b0, "rr_own3");
    step(4'b0111, 1'b0, 4'b0000, 1'b0, "rr_turn3");
    step(4'b1111, 1'b0, 4'b0001, 1'b0, "rr_own0_again");

    // wrap-around: owner 3 releases, ptr wraps to 0
    step(4'b1110, 1'b0, 4'b0000, 1'b0, "wrap_turn0");
    step(4'b1000, 1'b0, 4'b1000, 1'b0, "wrap_own3");
    step(4'b1001, 1'b0, 4'b1000, 1'b0, "wrap_nonowner_ignored");
    step(4'b0001, 1'b0, 4'b0000, 1'b0, "wrap_turn3");
    step(4'b1001, 1'b0, 4'b0001, 1'b0, "wrap_next_is_0");
    step(4'b0000, 1'b0, 4'b0000, 1'b0, "wrap_turn");
    step(4'b0000, 1'b0, 4'b0000, 1'b0, "wrap_idle");

    // hold limit with a competing request (ptr=1, owner 0 wins by wrap)
    step(4'b0001, 1'b0, 4'b0001, 1'b0, "hold_g1");
    step(4'b0011, 1'b0, 4'b0001, 1'b0, "hold_g2");
    step(4'b0011, 1'b0, 4'b0001, 1'b0, "hold_g3");
    step(4'b0011, 1'b0, 4'b0001, 1'b0, "hold_g4");
`ifdef BUS_ARB_TIMEOUT_EN
    step(4'b0011, 1'b0, 4'b0000, 1'b1, "timeout_pulse");
    step(4'b0011, 1'b0, 4'b0010, 1'b0, "timeout_next_owner");
    step(4'b0000, 1'b0, 4'b0000, 1'b0, "timeout_turn");
    step(4'b0000, 1'b0, 4'b0000, 1'b0, "timeout_idle");
    // owner drops exactly on the limit edge: normal release (ptr=2)
    step(4'b0001, 1'b0, 4'b0001, 1'b0, "limit_g1");
    step(4'b0011, 1'b0, 4'b0001, 1'b0, "limit_g2");
    step(4'b0011, 1'b0, 4'b0001, 1'b0, "limit_g3");
    step(4'b0011, 1'b0, 4'b0001, 1'b0, "limit_g4");
    step(4'b0010, 1'b0, 4'b0000, 1'b0, "limit_normal_release");
    step(4'b0010, 1'b0, 4'b0010, 1'b0, "limit_next_owner");
`else
    for (int i = 0; i < 100; i++)
      step(4'b0011, 1'b0, 4'b0001, 1'b0, "hold_no_timeout");
    step(4'b0010, 1'b0, 4'b0000, 1'b0, "hold_release");
    step(4'b0010, 1'b0, 4'b0010, 1'b0, "hold_next_owner");
`endif

    // sole requester keeps the bus past the hold limit
    for (int i = 0; i < 6; i++)
      step(4'b0010, 1'b0, 4'b0010, 1'b0, "sole_owner_keeps");
    step(4'b0000, 1'b0, 4'b0000, 1'b0, "sole_turn");
    step(4'b0000, 1'b0, 4'b0000, 1'b0, "sole_idle");

    // reset mid-grant of master 2 (ptr=2)
    step(4'b0100, 1'b0, 4'b0100, 1'b0, "midclr_own2");
    step(4'b0100, 1'b0, 4'b0100, 1'b0, "midclr_own2");
    step(4'b0100, 1'b1, 4'b0000, 1'b0, "midclr_drop");
    step(4'b0100, 1'b0, 4'b0100, 1'b0, "midclr_regrant");
    step(4'b0000, 1'b0, 4'b0000, 1'b0, "midclr_turn");
    step(4'b0000, 1'b0, 4'b0000, 1'b0, "midclr_idle");

    begin
      int k = 0;
      while (sb_q.size() != 0 && k < 10) begin
        @(negedge clock);
        #1;
        k++;
      end
    end
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
